alu_exec_ctrl: RTL and testbench

Sequencing controller that drives the 8-bit ALU from the initiator side. It accepts instructions over a valid/ready handshake and holds the accumulator A and operand register B. It presents op/A/B to the external ALU, captures O/c/z back into A and the flag register, and returns A over a result handshake on OUT. It sits between instruction fetch/decode and the combinational ALU in the seminar CPU.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_exec_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: opcodes, ALU op codes,
// controller states and default widths.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OPC_W_DEF  = 4;

  localparam logic [3:0] OPC_NOP = 4'd0;
  localparam logic [3:0] OPC_LDA = 4'd1;
  localparam logic [3:0] OPC_LDB = 4'd2;
  localparam logic [3:0] OPC_ADD = 4'd3;
  localparam logic [3:0] OPC_SUB = 4'd4;
  localparam logic [3:0] OPC_AND = 4'd5;
  localparam logic [3:0] OPC_OR  = 4'd6;
  localparam logic [3:0] OPC_OUT = 4'd7;
  localparam logic [3:0] OPC_CMP = 4'd8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Only meaningful for the four arithmetic/logic opcodes.
  function automatic logic [1:0] alu_op_of(input logic [3:0] opc);
    case (opc)
      OPC_SUB: alu_op_of = ALU_SUB;
      OPC_AND: alu_op_of = ALU_AND;
      OPC_OR:  alu_op_of = ALU_OR;
      default: alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_ctrl.sv
// Drives an external combinational ALU: accepts instructions, holds A/B/flags, returns A on OUT.
// Latency: LDA/LDB/NOP 1 edge, ALU ops 2 edges (accept + EXEC). ALU_CMP_EN enables opcode 8 (CMP).
// Backpressure: instr_ready only in IDLE; OUT holds res_valid/res_data until res_ready.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OPC_W-1:0]  instr_opcode,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              flag_c,
  output logic              flag_z,
  output logic              busy,
  output logic              err
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic [1:0]          op_q, op_d;
  logic                res_vld_q, res_vld_d;
  logic [DATA_W-1:0]   res_dat_q, res_dat_d;
  logic                err_q, err_d;
`ifdef ALU_CMP_EN
  // Marks that the current EXEC belongs to CMP, so A must not be written back.
  logic                cmp_q, cmp_d;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    z_d       = z_q;
    op_d      = op_q;
    res_vld_d = res_vld_q;
    res_dat_d = res_dat_q;
    err_d     = 1'b0;
`ifdef ALU_CMP_EN
    cmp_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          case (instr_opcode)
            OPC_NOP: ;
            OPC_LDA: a_d = instr_imm;
            OPC_LDB: b_d = instr_imm;
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
              op_d    = alu_op_of(instr_opcode);
              state_d = ST_EXEC;
            end
            OPC_OUT: begin
              res_dat_d = a_q;
              res_vld_d = 1'b1;
              state_d   = ST_OUT;
            end
`ifdef ALU_CMP_EN
            OPC_CMP: begin
              op_d    = ALU_SUB;
              cmp_d   = 1'b1;
              state_d = ST_EXEC;
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_EXEC: begin
        c_d     = alu_c;
        z_d     = alu_z;
`ifdef ALU_CMP_EN
        if (!cmp_q) a_d = alu_o;
`else
        a_d     = alu_o;
`endif
        state_d = ST_IDLE;
      end
      ST_OUT: begin
        if (res_ready) begin
          res_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      op_q      <= ALU_ADD;
      res_vld_q <= 1'b0;
      res_dat_q <= '0;
      err_q     <= 1'b0;
`ifdef ALU_CMP_EN
      cmp_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      z_q       <= z_d;
      op_q      <= op_d;
      res_vld_q <= res_vld_d;
      res_dat_q <= res_dat_d;
      err_q     <= err_d;
`ifdef ALU_CMP_EN
      cmp_q     <= cmp_d;
`endif
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign flag_c      = c_q;
  assign flag_z      = z_q;
  assign res_valid   = res_vld_q;
  assign res_data    = res_dat_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl with a behavioural 8-bit ALU beside it; vector table
// plus hand sequences for OUT backpressure and asynchronous reset.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_opcode = 4'd0;
  logic [7:0] instr_imm = 8'd0;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_o;
  logic       alu_c, alu_z;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       flag_c, flag_z, busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(8), .OPC_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_imm(instr_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .flag_c(flag_c), .flag_z(flag_z), .busy(busy), .err(err)
  );

  // External combinational ALU
  logic [8:0] alu_res;
  always_comb begin
    alu_res = 9'd0;
    case (alu_op)
      2'b00:   alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_res = {1'b0, alu_a & alu_b};
      default: alu_res = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_o = alu_res[7:0];
  assign alu_c = alu_res[8];
  assign alu_z = (alu_res[7:0] == 8'd0);

  typedef struct {
    logic [3:0] opc;
    logic [7:0] imm;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       z;
    logic [1:0] op;
    logic       err;
    logic       rdy1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] opc, logic [7:0] imm, logic [7:0] a, logic [7:0] b,
                              logic c, logic z, logic [1:0] op, logic e, logic rdy1);
    vec_t v;
    v.opc = opc; v.imm = imm; v.a = a; v.b = b; v.c = c; v.z = z;
    v.op = op; v.err = e; v.rdy1 = rdy1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for instr_ready, offers one instruction, returns 1ns after the accept edge.
  task automatic issue(input logic [3:0] opc, input logic [7:0] imm);
    @(negedge clk);
    for (int i = 0; i < 8 && !instr_ready; i++) @(negedge clk);
    if (!instr_ready) chk("issue_ready_timeout", {31'd0, instr_ready}, 32'd1);
    instr_valid  = 1'b1;
    instr_opcode = opc;
    instr_imm    = imm;
    @(posedge clk);
    #1;
    instr_valid  = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_instr_ready", instr_ready, 1);

    //                 opc      imm    A      B      c     z     op     err   rdy1
    vecs.push_back(mk(OPC_LDA, 8'hF0, 8'hF0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_LDB, 8'h20, 8'hF0, 8'h20, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_ADD, 8'h00, 8'h10, 8'h20, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    vecs.push_back(mk(OPC_LDA, 8'h05, 8'h05, 8'h20, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_LDB, 8'h05, 8'h05, 8'h05, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_SUB, 8'h00, 8'h00, 8'h05, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0));
    vecs.push_back(mk(OPC_LDA, 8'h03, 8'h03, 8'h05, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_SUB, 8'h00, 8'hFE, 8'h05, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0));
    vecs.push_back(mk(OPC_LDA, 8'hAA, 8'hAA, 8'h05, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_LDB, 8'h0F, 8'hAA, 8'h0F, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_AND, 8'h00, 8'h0A, 8'h0F, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0));
    vecs.push_back(mk(OPC_OR,  8'h00, 8'h0F, 8'h0F, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0));
    vecs.push_back(mk(OPC_NOP, 8'h99, 8'h0F, 8'h0F, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1));
    vecs.push_back(mk(4'hF,    8'h77, 8'h0F, 8'h0F, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1));
    vecs.push_back(mk(4'h9,    8'h77, 8'h0F, 8'h0F, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1));
    vecs.push_back(mk(OPC_NOP, 8'h00, 8'h0F, 8'h0F, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_LDA, 8'h03, 8'h03, 8'h0F, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1));
    vecs.push_back(mk(OPC_LDB, 8'h05, 8'h03, 8'h05, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1));
`ifdef ALU_CMP_EN
    vecs.push_back(mk(OPC_CMP, 8'h00, 8'h03, 8'h05, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0));
    vecs.push_back(mk(OPC_NOP, 8'h00, 8'h03, 8'h05, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1));
`else
    vecs.push_back(mk(OPC_CMP, 8'h00, 8'h03, 8'h05, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1));
    vecs.push_back(mk(OPC_NOP, 8'h00, 8'h03, 8'h05, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1));
`endif

    foreach (vecs[i]) begin
      issue(vecs[i].opc, vecs[i].imm);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_ready_after_accept", i), instr_ready, vecs[i].rdy1);
      if (!vecs[i].rdy1) begin
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_ready_after_exec", i), instr_ready, 1);
      end
      chk($sformatf("v%0d_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d_b", i), alu_b, vecs[i].b);
      chk($sformatf("v%0d_flag_c", i), flag_c, vecs[i].c);
      chk($sformatf("v%0d_flag_z", i), flag_z, vecs[i].z);
      chk($sformatf("v%0d_alu_op", i), alu_op, vecs[i].op);
    end

    // OUT held under backpressure for three cycles
    issue(OPC_LDA, 8'h5C);
    issue(OPC_OUT, 8'h00);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_hold%0d_valid", k), res_valid, 1);
      chk($sformatf("out_hold%0d_data", k), res_data, 8'h5C);
      chk($sformatf("out_hold%0d_ready", k), instr_ready, 0);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("out_done_valid", res_valid, 0);
    chk("out_done_ready", instr_ready, 1);
    chk("out_done_data_held", res_data, 8'h5C);

    // OUT with res_ready already high: single-cycle OUT
    issue(OPC_LDA, 8'h33);
    issue(OPC_OUT, 8'h00);
    chk("out1_valid", res_valid, 1);
    chk("out1_data", res_data, 8'h33);
    @(posedge clk);
    #1;
    chk("out1_done_valid", res_valid, 0);
    chk("out1_done_ready", instr_ready, 1);
    res_ready = 1'b0;

    // Asynchronous reset during EXEC aborts the write-back
    issue(OPC_LDA, 8'h01);
    issue(OPC_LDB, 8'h02);
    issue(OPC_SUB, 8'h00);
    @(posedge clk);
    #1;
    chk("pre_rst_a", alu_a, 8'hFF);
    chk("pre_rst_c", flag_c, 1);
    issue(OPC_ADD, 8'h00);
    chk("exec_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_exec_a", alu_a, 0);
    chk("arst_exec_b", alu_b, 0);
    chk("arst_exec_c", flag_c, 0);
    chk("arst_exec_z", flag_z, 0);
    chk("arst_exec_busy", busy, 0);
    chk("arst_exec_op", alu_op, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_a", alu_a, 0);
    chk("post_rst_c", flag_c, 0);
    chk("post_rst_ready", instr_ready, 1);

    // Asynchronous reset during OUT drops the pending result
    issue(OPC_LDA, 8'h44);
    issue(OPC_OUT, 8'h00);
    chk("pre_rst_out_valid", res_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", res_valid, 0);
    chk("arst_out_data", res_data, 0);
    chk("arst_out_ready", instr_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", res_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
